// File: rtl/jpeg_bayt_ayiklayici_pkg.sv
// Shared constants, state encoding and marker helper for the JPEG
// entropy-coded-segment byte cleaner (jpeg_bayt_ayiklayici).
package jpeg_bayt_ayiklayici_pkg;

  localparam logic [7:0] JPEG_MARKER_ONEK = 8'hFF;  // marker prefix / fill byte
  localparam logic [7:0] JPEG_EOI         = 8'hD9;  // end of image
  localparam logic [7:0] JPEG_RST0        = 8'hD0;  // first restart marker
  localparam logic [7:0] JPEG_DOLDURMA    = 8'h00;  // stuffing byte after 0xFF
  localparam logic [7:0] JPEG_RST_MASKE   = 8'hF8;  // selects D0..D7 as a group

  // Parser state: normal data, 0xFF held awaiting next byte, EOI seen
  typedef enum logic [1:0] {
    VERI     = 2'd0,
    FF_BEKLE = 2'd1,
    BITTI    = 2'd2
  } durum_t;

  // True for the eight restart markers 0xD0..0xD7
  function automatic logic rst_isaretcisi_mi(input logic [7:0] bayt);
    return (bayt & JPEG_RST_MASKE) == JPEG_RST0;
  endfunction

endpackage

// File: rtl/jpeg_bayt_ayiklayici.sv
// JPEG scan byte cleaner: removes 0xFF00 stuffing, absorbs 0xFF fill bytes,
// strips restart markers, detects EOI and forwards only entropy-coded bytes
// through a one-deep registered valid/ready output.
// Optional feature macro: JPEG_RST_EN (restart marker handling with
// expected-index checking controlled by RST_KONTROL). Without it, restart
// markers are reported as illegal and yeniden_o is tied low.
module jpeg_bayt_ayiklayici
  import jpeg_bayt_ayiklayici_pkg::*;
#(
  parameter int RST_KONTROL = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] g_veri_i,
  input  logic       g_gecerli_i,
  output logic       g_hazir_o,
  output logic [7:0] c_veri_o,
  output logic       c_gecerli_o,
  input  logic       c_hazir_i,
  input  logic       baslat_i,
  output logic       son_o,
  output logic       yeniden_o,
  output logic       hata_o
);

  durum_t     durum_q, durum_d;
  logic [7:0] veri_q, veri_d;
  logic       gecerli_q, gecerli_d;
  logic       son_q, son_d;
  logic       yeniden_q, yeniden_d;
  logic       hata_q, hata_d;

`ifdef JPEG_RST_EN
  logic [2:0] beklenen_q, beklenen_d;
`endif

  logic       g_hazir_s;
  logic       kabul_s;
  logic       yaz_s;
  logic [7:0] yaz_veri_s;
  durum_t     etkin_durum_s;

  // Input handshake: blocked after EOI and while the output slot cannot take a byte
  always_comb begin
    g_hazir_s = (durum_q != BITTI) && (!gecerli_q || c_hazir_i);
    kabul_s   = g_gecerli_i && g_hazir_s;
  end

  // Next-state, byte classification, pulse generation and output register load
  always_comb begin
    durum_d    = durum_q;
    veri_d     = veri_q;
    gecerli_d  = gecerli_q;
    son_d      = 1'b0;
    yeniden_d  = 1'b0;
    hata_d     = 1'b0;
    yaz_s      = 1'b0;
    yaz_veri_s = g_veri_i;
`ifdef JPEG_RST_EN
    beklenen_d = beklenen_q;
`endif

    // baslat_i re-arms: any held 0xFF is forgotten and the index restarts,
    // a byte accepted in the same cycle is parsed as if in VERI
    if (baslat_i) begin
      etkin_durum_s = VERI;
      durum_d       = VERI;
`ifdef JPEG_RST_EN
      beklenen_d    = 3'd0;
`endif
    end else begin
      etkin_durum_s = durum_q;
    end

    if (kabul_s) begin
      case (etkin_durum_s)
        VERI: begin
          if (g_veri_i == JPEG_MARKER_ONEK) begin
            durum_d = FF_BEKLE;
          end else begin
            yaz_s = 1'b1;
          end
        end
        FF_BEKLE: begin
          if (g_veri_i == JPEG_DOLDURMA) begin
            yaz_s      = 1'b1;
            yaz_veri_s = JPEG_MARKER_ONEK;
            durum_d    = VERI;
          end else if (g_veri_i == JPEG_MARKER_ONEK) begin
            durum_d = FF_BEKLE;
          end else if (g_veri_i == JPEG_EOI) begin
            son_d   = 1'b1;
            durum_d = BITTI;
          end else if (rst_isaretcisi_mi(g_veri_i)) begin
            durum_d = VERI;
`ifdef JPEG_RST_EN
            yeniden_d = 1'b1;
            if ((RST_KONTROL != 32'sd0) && (g_veri_i[2:0] != beklenen_q)) begin
              hata_d = 1'b1;
            end else begin
              hata_d = 1'b0;
            end
            beklenen_d = g_veri_i[2:0] + 3'd1;
`else
            hata_d = 1'b1;
`endif
          end else begin
            hata_d  = 1'b1;
            durum_d = VERI;
          end
        end
        BITTI: begin
          durum_d = BITTI;
        end
        default: begin
          durum_d = VERI;
        end
      endcase
    end else begin
      yaz_s = 1'b0;
    end

    // Output slot: load on emit, otherwise empty it once downstream takes it
    if (yaz_s) begin
      veri_d    = yaz_veri_s;
      gecerli_d = 1'b1;
    end else if (c_hazir_i) begin
      veri_d    = 8'h00;
      gecerli_d = 1'b0;
    end else begin
      veri_d    = veri_q;
      gecerli_d = gecerli_q;
    end
  end

  // State, output slot and pulse registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q    <= VERI;
      veri_q     <= 8'h00;
      gecerli_q  <= 1'b0;
      son_q      <= 1'b0;
      yeniden_q  <= 1'b0;
      hata_q     <= 1'b0;
`ifdef JPEG_RST_EN
      beklenen_q <= 3'd0;
`endif
    end else begin
      durum_q    <= durum_d;
      veri_q     <= veri_d;
      gecerli_q  <= gecerli_d;
      son_q      <= son_d;
      yeniden_q  <= yeniden_d;
      hata_q     <= hata_d;
`ifdef JPEG_RST_EN
      beklenen_q <= beklenen_d;
`endif
    end
  end

  assign g_hazir_o   = g_hazir_s;
  assign c_veri_o    = veri_q;
  assign c_gecerli_o = gecerli_q;
  assign son_o       = son_q;
  assign yeniden_o   = yeniden_q;
  assign hata_o      = hata_q;

endmodule

// File: tb/tb_jpeg_bayt_ayiklayici.sv
// Self-checking bench for jpeg_bayt_ayiklayici. Streams are scored against a
// stream-level reference model that walks the byte list by the JPEG rules.
// Expectations follow JPEG_RST_EN when it is defined for the build.
module tb_jpeg_bayt_ayiklayici;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] g_veri_i;
  logic       g_gecerli_i;
  logic       g_hazir_o;
  logic [7:0] c_veri_o;
  logic       c_gecerli_o;
  logic       c_hazir_i;
  logic       baslat_i;
  logic       son_o;
  logic       yeniden_o;
  logic       hata_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int e_son, e_yen, e_hata;
  int n_son, n_yen, n_hata;
  int sent;

  jpeg_bayt_ayiklayici dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .g_veri_i   (g_veri_i),
    .g_gecerli_i(g_gecerli_i),
    .g_hazir_o  (g_hazir_o),
    .c_veri_o   (c_veri_o),
    .c_gecerli_o(c_gecerli_o),
    .c_hazir_i  (c_hazir_i),
    .baslat_i   (baslat_i),
    .son_o      (son_o),
    .yeniden_o  (yeniden_o),
    .hata_o     (hata_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: walk the stream, pair each 0xFF (after fill) with its next byte
  function automatic void model();
    int i;
    int beklenen;
    logic [7:0] b;
    logic [7:0] m;
    i = 0;
    beklenen = 0;
    exp_q = {};
    e_son = 0; e_yen = 0; e_hata = 0;
    while (i < stim_q.size()) begin
      b = stim_q[i];
      i++;
      if (b != 8'hFF) begin
        exp_q.push_back(b);
      end else begin
        while (i < stim_q.size() && stim_q[i] == 8'hFF) i++;
        if (i >= stim_q.size()) break;
        m = stim_q[i];
        i++;
        if (m == 8'h00) begin
          exp_q.push_back(8'hFF);
        end else if (m == 8'hD9) begin
          e_son++;
          break;
        end else if (m >= 8'hD0 && m <= 8'hD7) begin
`ifdef JPEG_RST_EN
          e_yen++;
          if (int'(m) - 8'hD0 != beklenen) e_hata++;
          beklenen = (int'(m) - 8'hD0 + 1) % 8;
`else
          e_hata++;
`endif
        end else begin
          e_hata++;
        end
      end
    end
  endfunction

  function automatic bit same_q();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[k]) if (got_q[k] !== exp_q[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input bit gercek);
    string s;
    s = "";
    if (gercek) begin
      foreach (got_q[k]) s = {s, $sformatf("%02h ", got_q[k])};
    end else begin
      foreach (exp_q[k]) s = {s, $sformatf("%02h ", exp_q[k])};
    end
    return s;
  endfunction

  function automatic logic [7:0] rand_byte(input bit eoi_izin);
    int r;
    logic [7:0] v;
    r = $urandom_range(0, 99);
    if (r < 35)      v = 8'hFF;
    else if (r < 50) v = 8'h00;
    else if (r < 62) v = 8'hD0 + 8'($urandom_range(0, 7));
    else if (r < 64) v = 8'hD9;
    else if (r < 67) v = 8'hC4;
    else             v = 8'($urandom_range(0, 255));
    if (!eoi_izin && v == 8'hD9) v = 8'hDA;
    return v;
  endfunction

  // Drives stim_q through the DUT, collecting output bytes and pulse counts.
  // hazir_pct < 0 selects the repeating ready pattern 1,0,0,1.
  task automatic run_stream(input bit do_baslat, input int hazir_pct, input int gecerli_pct);
    int cyc;
    int drain;
    bit done_send;
    bit prev_stall;
    logic [7:0] prev_d;
    got_q = {};
    n_son = 0; n_yen = 0; n_hata = 0;
    sent = 0; cyc = 0; drain = 0;
    prev_stall = 1'b0;
    prev_d = 8'h00;
    if (do_baslat) begin
      baslat_i = 1'b1; g_gecerli_i = 1'b0; c_hazir_i = 1'b1;
      @(negedge clk_i);
      baslat_i = 1'b0;
    end
    while (1) begin
      done_send = (sent >= stim_q.size()) || (n_son > 0);
      g_gecerli_i = !done_send && ($urandom_range(0, 99) < gecerli_pct);
      g_veri_i = done_send ? 8'h00 : stim_q[sent];
      if (done_send) c_hazir_i = 1'b1;
      else if (hazir_pct < 0) c_hazir_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      else c_hazir_i = ($urandom_range(0, 99) < hazir_pct);
      #1;
      if (son_o) n_son++;
      if (yeniden_o) n_yen++;
      if (hata_o) n_hata++;
      if (prev_stall) begin
        tests++;
        if (c_gecerli_o !== 1'b1 || c_veri_o !== prev_d) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b data=%02h, required valid=1 data=%02h",
                   c_gecerli_o, c_veri_o, prev_d);
        end
      end
      if (c_gecerli_o && c_hazir_i) got_q.push_back(c_veri_o);
      if (g_gecerli_i && g_hazir_o) sent++;
      prev_stall = c_gecerli_o && !c_hazir_i;
      prev_d = c_veri_o;
      @(negedge clk_i);
      cyc++;
      if (done_send) drain++;
      if (drain >= 6) break;
      if (cyc > 3000) begin
        tests++; fails++;
        $display("FAIL run_timeout: sent %0d of %0d bytes within 3000 cycles", sent, stim_q.size());
        break;
      end
    end
    g_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; g_veri_i = 8'h00; g_gecerli_i = 1'b0; c_hazir_i = 1'b1; baslat_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    tests++;
    if ({c_veri_o, c_gecerli_o, son_o, yeniden_o, hata_o, g_hazir_o} !== 13'h0001) begin
      fails++;
      $display("FAIL reset_state: got data=%02h v=%b son=%b yen=%b hata=%b rdy=%b, required 00 0 0 0 0 1",
               c_veri_o, c_gecerli_o, son_o, yeniden_o, hata_o, g_hazir_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_timing();
    logic [7:0] v;
    v = 8'($urandom_range(0, 254));
    baslat_i = 1'b1; c_hazir_i = 1'b1; g_gecerli_i = 1'b0;
    @(negedge clk_i);
    baslat_i = 1'b0; g_gecerli_i = 1'b1; g_veri_i = v;
    #1;
    tests++;
    if (g_hazir_o !== 1'b1) begin
      fails++; $display("FAIL idle_ready: got %b required 1", g_hazir_o);
    end
    @(negedge clk_i);
    g_gecerli_i = 1'b0;
    #1;
    tests++;
    if (c_gecerli_o !== 1'b1 || c_veri_o !== v) begin
      fails++; $display("FAIL latency: got v=%b d=%02h required v=1 d=%02h", c_gecerli_o, c_veri_o, v);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (c_gecerli_o !== 1'b0) begin
      fails++; $display("FAIL drain_clear: got %b required 0", c_gecerli_o);
    end
    @(negedge clk_i);
    g_gecerli_i = 1'b1; g_veri_i = 8'hFF;
    @(negedge clk_i);
    g_veri_i = 8'hD9;
    @(negedge clk_i);
    g_gecerli_i = 1'b0;
    #1;
    tests++;
    if (son_o !== 1'b1) begin
      fails++; $display("FAIL eoi_pulse: got %b required 1", son_o);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (son_o !== 1'b0 || g_hazir_o !== 1'b0) begin
      fails++; $display("FAIL eoi_after: got son=%b rdy=%b required 0 0", son_o, g_hazir_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_stuffing();
    stim_q = {8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};
    model();
    run_stream(1'b1, 100, 100);
    tests++;
    if (!same_q()) begin
      fails++; $display("FAIL stuffing_data: got %s required %s", q2s(1'b1), q2s(1'b0));
    end
    tests++;
    if (n_son != e_son || n_yen != e_yen || n_hata != e_hata) begin
      fails++; $display("FAIL stuffing_pulses: got %0d/%0d/%0d required %0d/%0d/%0d",
                        n_son, n_yen, n_hata, e_son, e_yen, e_hata);
    end
    stim_q = {8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    model();
    run_stream(1'b1, 100, 100);
    tests++;
    if (!same_q()) begin
      fails++; $display("FAIL fill_data: got %s required %s", q2s(1'b1), q2s(1'b0));
    end
  endtask

  task automatic test_eoi();
    stim_q = {8'h01, 8'hFF, 8'hD9, 8'h02};
    model();
    run_stream(1'b1, 100, 100);
    tests++;
    if (!same_q() || n_son != 1 || n_son != e_son || n_hata != e_hata || sent != 3) begin
      fails++; $display("FAIL eoi_stream: got %s son=%0d hata=%0d sent=%0d required %s son=%0d hata=%0d sent=3",
                        q2s(1'b1), n_son, n_hata, sent, q2s(1'b0), e_son, e_hata);
    end
    g_gecerli_i = 1'b1; g_veri_i = 8'h02; c_hazir_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (g_hazir_o !== 1'b0 || c_gecerli_o !== 1'b0) begin
        fails++; $display("FAIL eoi_stall: got rdy=%b v=%b required 0 0", g_hazir_o, c_gecerli_o);
      end
      @(negedge clk_i);
    end
    baslat_i = 1'b1;
    @(negedge clk_i);
    baslat_i = 1'b0;
    #1;
    tests++;
    if (g_hazir_o !== 1'b1) begin
      fails++; $display("FAIL rearm_ready: got %b required 1", g_hazir_o);
    end
    @(negedge clk_i);
    g_gecerli_i = 1'b0;
    #1;
    tests++;
    if (c_gecerli_o !== 1'b1 || c_veri_o !== 8'h02) begin
      fails++; $display("FAIL rearm_data: got v=%b d=%02h required v=1 d=02", c_gecerli_o, c_veri_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_restart();
    stim_q = {8'hFF, 8'hD0, 8'hFF, 8'hD1, 8'hFF, 8'hD3};
    model();
    run_stream(1'b1, 100, 100);
    tests++;
    if (got_q.size() != 0 || n_yen != e_yen || n_hata != e_hata || n_son != 0) begin
      fails++; $display("FAIL restart: got %0d bytes yen=%0d hata=%0d son=%0d required 0 bytes yen=%0d hata=%0d son=0",
                        got_q.size(), n_yen, n_hata, n_son, e_yen, e_hata);
    end
  endtask

  task automatic test_backpressure();
    stim_q = {8'h11, 8'h22, 8'h33};
    model();
    run_stream(1'b1, -1, 100);
    tests++;
    if (!same_q()) begin
      fails++; $display("FAIL backpressure: got %s required %s", q2s(1'b1), q2s(1'b0));
    end
  endtask

  task automatic test_reset_mid();
    baslat_i = 1'b1; c_hazir_i = 1'b1; g_gecerli_i = 1'b0;
    @(negedge clk_i);
    baslat_i = 1'b0; g_gecerli_i = 1'b1; g_veri_i = 8'h12;
    @(negedge clk_i);
    g_gecerli_i = 1'b0; c_hazir_i = 1'b0;
    #1;
    tests++;
    if (c_gecerli_o !== 1'b1) begin
      fails++; $display("FAIL pre_reset_hold: got %b required 1", c_gecerli_o);
    end
    rst_i = 1'b1;
    #1;
    tests++;
    if ({c_gecerli_o, c_veri_o, son_o, yeniden_o, hata_o} !== 12'h000) begin
      fails++; $display("FAIL async_reset: got v=%b d=%02h required v=0 d=00", c_gecerli_o, c_veri_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0; c_hazir_i = 1'b1; g_gecerli_i = 1'b1; g_veri_i = 8'hFF;
    @(negedge clk_i);
    g_gecerli_i = 1'b0; rst_i = 1'b1;
    #1;
    tests++;
    if ({c_gecerli_o, c_veri_o, son_o, yeniden_o, hata_o} !== 12'h000) begin
      fails++; $display("FAIL reset_outputs: got v=%b d=%02h son=%b yen=%b hata=%b required all 0",
                        c_gecerli_o, c_veri_o, son_o, yeniden_o, hata_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    stim_q = {8'h00};
    model();
    run_stream(1'b0, 100, 100);
    tests++;
    if (!same_q() || n_hata != 0) begin
      fails++; $display("FAIL reset_drops_ff: got %s hata=%0d required %s hata=0", q2s(1'b1), n_hata, q2s(1'b0));
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(20, 40);
      stim_q = {};
      for (int k = 0; k < len; k++) stim_q.push_back(rand_byte(it >= 8));
      model();
      run_stream(1'b1, (it % 3 == 0) ? 100 : 60, (it % 2 == 0) ? 100 : 75);
      tests++;
      if (!same_q()) begin
        fails++; $display("FAIL random_data[%0d]: got %s required %s", it, q2s(1'b1), q2s(1'b0));
      end
      tests++;
      if (n_son != e_son || n_yen != e_yen || n_hata != e_hata) begin
        fails++; $display("FAIL random_pulses[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                          it, n_son, n_yen, n_hata, e_son, e_yen, e_hata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_stuffing();
    test_eoi();
    test_restart();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
